mm2d_stream_out: RTL and testbench
==================================

// Module: mm2d_stream_out
// PURPOSE
//  Drains the banked result matrix D out of the systolic array into a 32-bit AXI-Stream master
//  (the memory-to-stream direction of the matrix datapath).
//  Streams one complete matrix per start handshake, in row-major order, with tlast on the final beat.
//  Signals the end of readout so the multiply controller can drop done_multiply and accept the next A/B batch.
// PARAMETERS
//  D_W          32  result element width, 1..32 bits, signed
//  N            4   number of D banks (column interleave factor)
//  MATRIXSIZE_W 16  width of the matrix size inputs
//  ADDR_W       12  bank address width
//  FIFO_DEPTH   4   output buffer depth, power of 2, >=2
// PORTS
//  clk          in   1              clock
//  rst          in   1              synchronous, active-high reset
//  d_ready      in   1              level; high = D fully written and ready to read (done_multiply)
//  M1           in   MATRIXSIZE_W   number of D rows; sampled at start
//  M3dN         in   MATRIXSIZE_W   D columns / N; sampled at start
//  rd_addr      out  ADDR_W         shared bank read address
//  rd_en        out  N              one-hot bank read enable
//  D_bram       in   N x D_W        bank read data, valid 1 clk after rd_en
//  m_axis_tdata out  32             element, sign-extended from D_W
//  m_axis_tvalid out 1              AXI-S valid
//  m_axis_tready in  1              AXI-S ready
//  m_axis_tlast out  1              high on final beat of the matrix
//  read_done    out  1              1-cycle pulse after final beat accepted
//  stall_cnt    out  32             backpressure cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO flushed, in-flight reads discarded, FSM to IDLE. Reset mid-stream aborts the matrix.
//  - Element (r,c) lives in bank c%N at address r*M3dN + c/N. Beat order: r=0..M1-1, k=0..M3dN-1, bank=0..N-1.
//  - Total beats = M1*M3dN*N.
//  - FSM:
//      IDLE:     d_ready rise (d_ready & ~d_ready_q) -> latch M1/M3dN, clear counters, go STREAM.
//                If M1==0 or M3dN==0 -> DONE instead.
//      STREAM:   issue reads; once all reads are issued -> DRAIN.
//      DRAIN:    last beat accepted (tvalid&tready&tlast) -> DONE.
//      DONE:     read_done=1 for exactly one cycle -> WAIT_LOW.
//      WAIT_LOW: stay until d_ready==0 -> IDLE. No re-trigger while d_ready is held high.
//  - Read issue: one read per clk when (fifo_count + inflight) < FIFO_DEPTH.
//      rd_en = onehot(bank), rd_addr = row*M3dN + k, both registered.
//      Bank counter wraps N-1->0 and advances k. k wraps M3dN-1->0 and advances row.
//      Address is an incrementing counter, no multiplier.
//  - Capture: bank select is delayed 1 clk; D_bram[bank_q] is pushed to the FIFO together with a last flag
//    (set on the final issued read). FIFO never overflows by construction.
//  - Output: tvalid = FIFO non-empty; tdata/tlast = FIFO head. Pop on tvalid&tready.
//    tdata/tlast are stable while tvalid&~tready. tvalid never drops without a handshake.
//  - Latency: first tvalid 3 clk after the d_ready rise is sampled. Sustains 1 beat/clk with tready=1.
//  - Simultaneous FIFO push and pop: count is unchanged. Full FIFO blocks issue, never the capture.
//  - M1, M3dN changes after start: ignored until the next start.
// CONFIGURATION
//  MM2D_STALL_CNT_EN defined:
//    stall_cnt counts cycles with tvalid&~tready.
//    Cleared at each start and on rst; saturates at 2^32-1; holds its value after DONE.
//  Not defined: stall_cnt tied to 0; no counter logic.
// TESTING
//  1. N=4, M1=2, M3dN=1, tready=1, bank b addr a holds 16*a+b
//       -> 8 beats 0,1,2,3,16,17,18,19; tlast only on beat 8; read_done 1 clk after beat 8.
//  2. Same setup, tready alternating 1,0,1,0
//       -> same 8 values, no drop or duplicate; tdata/tlast stable across every stalled cycle.
//  3. M1=4, M3dN=2, tready=0 for 20 clk, then 1
//       -> rd_en pulses stop after exactly 4 reads until the first pop; 32 beats total;
//          stall_cnt=20 with MM2D_STALL_CNT_EN, 0 without.
//  4. D_W=16, element 0x8001 -> tdata=0xFFFF8001; element 0x7FFF -> tdata=0x00007FFF.
//  5. rst asserted after beat 3 of test 1 -> tvalid=0, rd_en=0 next clk;
//     new d_ready rise -> full 8-beat sequence from 0.
//  6. M1=0 -> no tvalid, read_done pulse.
//     d_ready held high after read_done -> no second transfer; low then high -> new transfer.

Source files
------------

// File: rtl/mm2d_stream_out.sv
// rtl/mm2d_stream_out.sv - drains banked result matrix D into a 32-bit AXI-Stream master
// Optional feature macro: MM2D_STALL_CNT_EN (backpressure cycle counter on stall_cnt)
module mm2d_stream_out #(
   parameter int D_W          = 32,
   parameter int N            = 4,
   parameter int MATRIXSIZE_W = 16,
   parameter int ADDR_W       = 12,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    d_ready,
   input  logic [MATRIXSIZE_W-1:0] M1,
   input  logic [MATRIXSIZE_W-1:0] M3dN,
   output logic [ADDR_W-1:0]       rd_addr,
   output logic [N-1:0]            rd_en,
   input  logic [N*D_W-1:0]        D_bram,
   output logic [31:0]             m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic                    read_done,
   output logic [31:0]             stall_cnt
);

   localparam int BW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE, S_WAIT_LOW} state_t;

   state_t                  r_state, w_state_nx;
   logic                    r_d_ready_q;
   logic [MATRIXSIZE_W-1:0] r_m1, r_m3dn, r_row, r_k;
   logic [BW-1:0]           r_bank, r_rd_bank, r_cap_bank;
   logic [ADDR_W-1:0]       r_addr_cnt, r_rd_addr;
   logic [N-1:0]            r_rd_en;
   logic                    r_rd_last, r_cap_valid, r_cap_last;
   logic [D_W-1:0]          r_fifo_data [FIFO_DEPTH];
   logic                    r_fifo_last [FIFO_DEPTH];
   logic [PW-1:0]           r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]           r_count;

   logic                    w_start, w_issue, w_can_issue, w_last_rd, w_push, w_pop, w_head_last;
   logic [CW:0]             w_occupancy;
   logic [D_W-1:0]          w_bank_data [N];
   logic signed [D_W-1:0]   w_head_s;
   logic [31:0]             w_head_ext;

   genvar g;
   for (g = 0; g < N; g++) begin : g_unpack
      assign w_bank_data[g] = D_bram[g*D_W +: D_W];
   end

   assign w_start     = d_ready & ~r_d_ready_q;
   assign w_push      = r_cap_valid;
   assign w_pop       = m_axis_tvalid & m_axis_tready;
   // FIFO entries plus reads still in the BRAM/capture pipe; capping this keeps capture from ever overflowing
   assign w_occupancy = {1'b0, r_count} + (CW+1)'(|r_rd_en) + (CW+1)'(r_cap_valid);
   assign w_can_issue = w_occupancy < (CW+1)'(FIFO_DEPTH);
   assign w_last_rd   = (r_row == r_m1 - MATRIXSIZE_W'(1)) && (r_k == r_m3dn - MATRIXSIZE_W'(1)) &&
                        (r_bank == BW'(N-1));
   assign w_head_last = r_fifo_last[r_rd_ptr];
   assign w_head_s    = r_fifo_data[r_rd_ptr];
   assign w_head_ext  = 32'(w_head_s);

   assign m_axis_tvalid = (r_count != '0);
   assign m_axis_tdata  = m_axis_tvalid ? w_head_ext : 32'd0;
   assign m_axis_tlast  = m_axis_tvalid & w_head_last;
   assign rd_en         = r_rd_en;
   assign rd_addr       = r_rd_addr;

   // State register and d_ready edge history
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_d_ready_q <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_d_ready_q <= d_ready;
      end
   end

   // Next-state, read issue and completion pulse
   always_comb begin
      w_state_nx = r_state;
      w_issue    = 1'b0;
      read_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start)
               w_state_nx = ((M1 == '0) || (M3dN == '0)) ? S_DONE : S_STREAM;
         end
         S_STREAM: begin
            if (w_can_issue) begin
               w_issue = 1'b1;
               if (w_last_rd) w_state_nx = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_pop && w_head_last) w_state_nx = S_DONE;
         end
         S_DONE: begin
            read_done  = 1'b1;
            w_state_nx = S_WAIT_LOW;
         end
         S_WAIT_LOW: begin
            if (!d_ready) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Sizes latched at start; bank/k/row walk with a flat incrementing address
   always_ff @(posedge clk) begin
      if (rst) begin
         r_m1 <= '0; r_m3dn <= '0; r_row <= '0; r_k <= '0; r_bank <= '0; r_addr_cnt <= '0;
      end else if (r_state == S_IDLE && w_start) begin
         r_m1 <= M1; r_m3dn <= M3dN; r_row <= '0; r_k <= '0; r_bank <= '0; r_addr_cnt <= '0;
      end else if (w_issue) begin
         if (r_bank == BW'(N-1)) begin
            r_bank     <= '0;
            r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
            if (r_k == r_m3dn - MATRIXSIZE_W'(1)) begin
               r_k   <= '0;
               r_row <= r_row + MATRIXSIZE_W'(1);
            end else begin
               r_k <= r_k + MATRIXSIZE_W'(1);
            end
         end else begin
            r_bank <= r_bank + BW'(1);
         end
      end
   end

   // Registered read port, then bank/last tag aligned with returning BRAM data
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_en <= '0; r_rd_addr <= '0; r_rd_bank <= '0; r_rd_last <= 1'b0;
         r_cap_valid <= 1'b0; r_cap_bank <= '0; r_cap_last <= 1'b0;
      end else begin
         r_rd_en     <= w_issue ? (N'(1) << r_bank) : '0;
         r_rd_last   <= w_issue & w_last_rd;
         if (w_issue) begin
            r_rd_addr <= r_addr_cnt;
            r_rd_bank <= r_bank;
         end
         r_cap_valid <= |r_rd_en;
         r_cap_bank  <= r_rd_bank;
         r_cap_last  <= r_rd_last;
      end
   end

   // FIFO storage, written by capture only
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_data[r_wr_ptr] <= w_bank_data[r_cap_bank];
         r_fifo_last[r_wr_ptr] <= r_cap_last;
      end
   end

   // FIFO pointers and count; push and pop together leave count unchanged
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0; r_rd_ptr <= '0; r_count <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef MM2D_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   // Saturating count of cycles the sink held off a valid beat
   always_ff @(posedge clk) begin
      if (rst)
         r_stall_cnt <= '0;
      else if (r_state == S_IDLE && w_start)
         r_stall_cnt <= '0;
      else if (m_axis_tvalid && !m_axis_tready && r_stall_cnt != 32'hFFFF_FFFF)
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mm2d_stream_out.sv
// tb/tb_mm2d_stream_out.sv - randomized self-checking bench for mm2d_stream_out
module tb_mm2d_stream_out;
   localparam int N  = 4;
   localparam int AW = 12;
   localparam int MW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          d_ready = 1'b0;
   logic          tready = 1'b0;
   logic [MW-1:0] m1 = '0, m3dn = '0;

   logic [AW-1:0]   rd_addr, rd_addr_h;
   logic [N-1:0]    rd_en, rd_en_h;
   logic [31:0]     tdata, tdata_h, stall_cnt, stall_cnt_h;
   logic            tvalid, tvalid_h, tlast, tlast_h, read_done, read_done_h;
   logic [N*32-1:0] dbram;
   logic [N*16-1:0] dbram_h;

   logic [31:0] mem [N][256];
   logic [31:0] q   [N];
   logic [31:0] qh  [N];

   int n_checks = 0;
   int n_fail   = 0;

   mm2d_stream_out #(.D_W(32), .N(N), .MATRIXSIZE_W(MW), .ADDR_W(AW), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .d_ready(d_ready), .M1(m1), .M3dN(m3dn),
      .rd_addr(rd_addr), .rd_en(rd_en), .D_bram(dbram),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .m_axis_tlast(tlast), .read_done(read_done), .stall_cnt(stall_cnt));

   mm2d_stream_out #(.D_W(16), .N(N), .MATRIXSIZE_W(MW), .ADDR_W(AW), .FIFO_DEPTH(4)) dut_h (
      .clk(clk), .rst(rst), .d_ready(d_ready), .M1(m1), .M3dN(m3dn),
      .rd_addr(rd_addr_h), .rd_en(rd_en_h), .D_bram(dbram_h),
      .m_axis_tdata(tdata_h), .m_axis_tvalid(tvalid_h), .m_axis_tready(tready),
      .m_axis_tlast(tlast_h), .read_done(read_done_h), .stall_cnt(stall_cnt_h));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      for (int b = 0; b < N; b++) begin
         if (rd_en[b])   q[b]  <= mem[b][rd_addr[7:0]];
         if (rd_en_h[b]) qh[b] <= mem[b][rd_addr_h[7:0]];
      end
   end

   always_comb begin
      dbram   = '0;
      dbram_h = '0;
      for (int b = 0; b < N; b++) begin
         dbram[b*32 +: 32]   = q[b];
         dbram_h[b*16 +: 16] = qh[b][15:0];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // fill: 0 random, 1 pattern 16*a+b, 2 random with signed edge values
   // mode: 0 tready=1, 1 alternating, 2 hold off 20 stall cycles, 3 random
   task automatic run_matrix(input int mr, input int mk, input int mode, input int fill);
      logic [31:0] exp_q[$];
      logic [31:0] e, prev_data;
      logic        prev_last, prev_stall, done, bad;
      int          hs, stalls, rdcnt, first_valid, last_hs_cyc;
      for (int b = 0; b < N; b++)
         for (int a = 0; a < 256; a++)
            mem[b][a] = (fill == 1) ? 32'(16*a + b) : $urandom;
      if (fill == 2) begin
         mem[0][0] = 32'h0000_8001;
         mem[1][0] = 32'h0000_7FFF;
      end
      for (int r = 0; r < mr; r++)
         for (int c = 0; c < mk*N; c++)
            exp_q.push_back(mem[c % N][r*mk + c/N]);
      hs = 0; stalls = 0; rdcnt = 0; first_valid = 0; last_hs_cyc = -10;
      prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; done = 1'b0;
      @(negedge clk);
      m1 = MW'(mr); m3dn = MW'(mk); d_ready = 1'b1;
      for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
         @(negedge clk);
         if (cyc == 2) begin m1 = MW'($urandom); m3dn = MW'($urandom); end
         case (mode)
            0:       tready = 1'b1;
            1:       tready = (cyc % 2 == 1);
            2:       tready = (stalls >= 20);
            default: tready = 1'($urandom_range(0, 1));
         endcase
         if (prev_stall) begin
            check_eq("hold_valid", 32'(tvalid), 32'd1);
            check_eq("hold_data", tdata, prev_data);
            check_eq("hold_last", 32'(tlast), 32'(prev_last));
         end
         if (tvalid && first_valid == 0) first_valid = cyc;
         if (hs == 0 && (|rd_en)) rdcnt++;
         if (read_done) begin
            if (mr*mk > 0) check_eq("read_done_timing", 32'(cyc), 32'(last_hs_cyc + 1));
            done = 1'b1;
         end
         if (tvalid && tready) begin
            if (exp_q.size() == 0) begin
               check_eq("extra_beat", 32'(hs), 32'(mr*mk*N));
            end else begin
               e = exp_q.pop_front();
               check_eq("tdata", tdata, e);
               check_eq("tlast", 32'(tlast), 32'(exp_q.size() == 0));
               check_eq("tdata_d16", tdata_h, {{16{e[15]}}, e[15:0]});
            end
            hs++;
            last_hs_cyc = cyc;
         end
         prev_stall = tvalid && !tready;
         if (prev_stall) stalls++;
         prev_data = tdata;
         prev_last = tlast;
      end
      check_eq("read_done_seen", 32'(done), 32'd1);
      check_eq("beat_count", 32'(hs), 32'(mr*mk*N));
      if (mr*mk > 0) check_eq("first_valid_latency", 32'(first_valid), 32'd4);
      else           check_eq("no_valid_empty", 32'(first_valid), 32'd0);
      if (mode == 2) check_eq("reads_before_pop", 32'(rdcnt), 32'd4);
`ifdef MM2D_STALL_CNT_EN
      check_eq("stall_cnt", stall_cnt, 32'(stalls));
`else
      check_eq("stall_cnt", stall_cnt, 32'd0);
`endif
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bad = bad | tvalid | read_done | (|rd_en);
      end
      check_eq("no_retrigger", 32'(bad), 32'd0);
      d_ready = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic run_abort();
      int hs;
      for (int b = 0; b < N; b++)
         for (int a = 0; a < 256; a++)
            mem[b][a] = 32'(16*a + b);
      hs = 0;
      @(negedge clk);
      m1 = MW'(2); m3dn = MW'(1); d_ready = 1'b1; tready = 1'b1;
      for (int cyc = 0; cyc < 50 && hs < 3; cyc++) begin
         @(negedge clk);
         if (tvalid && tready) hs++;
      end
      check_eq("abort_beats", 32'(hs), 32'd3);
      @(negedge clk);
      rst = 1'b1; d_ready = 1'b0;
      @(negedge clk);
      check_eq("abort_tvalid", 32'(tvalid), 32'd0);
      check_eq("abort_rd_en", 32'(rd_en), 32'd0);
      check_eq("abort_tdata", tdata, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_eq("rst_tvalid", 32'(tvalid), 32'd0);
      check_eq("rst_rd_en", 32'(rd_en), 32'd0);
      check_eq("rst_rd_addr", 32'(rd_addr), 32'd0);
      check_eq("rst_tdata", tdata, 32'd0);
      check_eq("rst_tlast", 32'(tlast), 32'd0);
      check_eq("rst_read_done", 32'(read_done), 32'd0);
      check_eq("rst_stall_cnt", stall_cnt, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_matrix(2, 1, 0, 1);
      run_matrix(2, 1, 1, 1);
      run_matrix(4, 2, 2, 0);
      run_matrix(3, 2, 3, 2);
      run_abort();
      run_matrix(2, 1, 0, 1);
      run_matrix(0, 3, 0, 0);
      run_matrix(1, 1, 0, 0);
      for (int i = 0; i < 4; i++)
         run_matrix($urandom_range(1, 5), $urandom_range(1, 3), 3, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
